// File: rtl/msx_joyport.sv
`timescale 1ns/1ps
// Two-player MSX general-purpose joystick port driver: input sync, SOCD resolution, autofire.
// Autofire engine (prescaler, phase logic, af_rate decode) is built only with MSXJOY_AUTOFIRE_EN.
module msx_joyport #(
    parameter int unsigned TICK_DIV = 21477,
    parameter int unsigned AF_P1    = 62,
    parameter int unsigned AF_P2    = 42,
    parameter int unsigned AF_P3    = 33
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [3:0] p1_dir,
    input  logic [1:0] p1_trig,
    input  logic [1:0] p1_turbo,
    input  logic [3:0] p2_dir,
    input  logic [1:0] p2_trig,
    input  logic [1:0] p2_turbo,
    input  logic [1:0] socd_mode,
    input  logic [1:0] af_rate,
    input  logic       psg_port_sel,
    output logic [5:0] joy1_n,
    output logic [5:0] joy2_n,
    output logic [5:0] psg_joy_n
);

    if (TICK_DIV < 2 || TICK_DIV > 65535 || AF_P1 == 0 || AF_P2 == 0 || AF_P3 == 0) begin : g_param_check
        $error("msx_joyport: parameter out of range");
    end

    logic [1:0]  rst_q;
    logic        rst_i;
    logic [15:0] s1, s2;
    logic [1:0]  socd_q;
    logic [11:0] joy_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rst_q <= '0;
        else          rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_i = rst_q[1];

    // psg_port_sel bypasses the config register so the PSG view follows it in one cycle.
    always_ff @(posedge clk_sys or negedge rst_i) begin
        if (!rst_i) begin
            s1        <= '0;
            s2        <= '0;
            socd_q    <= '0;
            joy1_n    <= '1;
            joy2_n    <= '1;
            psg_joy_n <= '1;
        end else begin
            s1        <= {p2_turbo, p2_trig, p2_dir, p1_turbo, p1_trig, p1_dir};
            s2        <= s1;
            socd_q    <= socd_mode;
            joy1_n    <= ~joy_d[5:0];
            joy2_n    <= ~joy_d[11:6];
            psg_joy_n <= psg_port_sel ? joy2_n : joy1_n;
        end
    end

`ifdef MSXJOY_AUTOFIRE_EN
    logic [1:0]  rate_q;
    logic [15:0] pre;
    logic [15:0] period_m1;
    logic        tick;

    assign tick = (pre == 16'(TICK_DIV - 1));

    always_ff @(posedge clk_sys or negedge rst_i) begin
        if (!rst_i) begin
            rate_q <= '0;
            pre    <= '0;
        end else begin
            rate_q <= af_rate;
            pre    <= tick ? '0 : pre + 16'd1;
        end
    end

    always_comb begin
        case (rate_q)
            2'd1:    period_m1 = 16'(AF_P1 - 1);
            2'd2:    period_m1 = 16'(AF_P2 - 1);
            default: period_m1 = 16'(AF_P3 - 1);
        endcase
    end
`else
    logic unused_af_rate;
    assign unused_af_rate = ^af_rate;
`endif

    function automatic logic next_last(input logic [1:0] rise, input logic last);
        logic r;
        r = last;
        if (rise[0])      r = 1'b0;
        else if (rise[1]) r = 1'b1;
        return r;
    endfunction

    function automatic logic [1:0] resolve(input logic [1:0] pair, input logic [1:0] mode,
                                           input logic last_hi);
        logic [1:0] r;
        r = pair;
        if (pair == 2'b11) begin
            case (mode)
                2'd0:    r = 2'b11;
                2'd2:    r = last_hi ? 2'b10 : 2'b01;
                default: r = 2'b00;
            endcase
        end
        return r;
    endfunction

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic [3:0] dir, dir_prev, rise, dir_res;
        logic [1:0] trig, turbo, trig_res;
        logic [1:0] last, last_nxt;

        assign {turbo, trig, dir} = s2[p*8 +: 8];
        assign rise = dir & ~dir_prev;

        // last bit per axis: 0 = up/left rose most recently, 1 = down/right
        always_comb begin
            last_nxt[0]  = next_last(rise[1:0], last[0]);
            last_nxt[1]  = next_last(rise[3:2], last[1]);
            dir_res[1:0] = resolve(dir[1:0], socd_q, last_nxt[0]);
            dir_res[3:2] = resolve(dir[3:2], socd_q, last_nxt[1]);
        end

        always_ff @(posedge clk_sys or negedge rst_i) begin
            if (!rst_i) begin
                dir_prev <= '0;
                last     <= '0;
            end else begin
                dir_prev <= dir;
                last     <= last_nxt;
            end
        end

`ifdef MSXJOY_AUTOFIRE_EN
        logic        turbo_prev, phase, phase_nxt, any, rise_t;
        logic [15:0] cnt, cnt_nxt;

        // A turbo rise forces the fire phase in the same cycle; restart beats a coincident tick.
        always_comb begin
            any       = |turbo;
            rise_t    = any & ~turbo_prev;
            phase_nxt = phase;
            cnt_nxt   = cnt;
            if (rate_q == 2'd0 || !any) begin
                phase_nxt = 1'b0;
                cnt_nxt   = '0;
            end else if (rise_t) begin
                phase_nxt = 1'b1;
                cnt_nxt   = '0;
            end else if (tick) begin
                if (cnt >= period_m1) begin
                    phase_nxt = ~phase;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            if (rate_q == 2'd0) trig_res = trig | turbo;
            else                trig_res = trig | (turbo & {2{rise_t | phase}});
        end

        always_ff @(posedge clk_sys or negedge rst_i) begin
            if (!rst_i) begin
                turbo_prev <= 1'b0;
                phase      <= 1'b0;
                cnt        <= '0;
            end else begin
                turbo_prev <= any;
                phase      <= phase_nxt;
                cnt        <= cnt_nxt;
            end
        end
`else
        assign trig_res = trig | turbo;
`endif

        assign joy_d[p*6 +: 6] = {trig_res, dir_res};
    end

endmodule

// File: doc/msx_joyport.md
Name: msx_joyport

Overview:
- Downstream consumer of the Pocket gamepad decoder.
- Converts two players' decoded D-pad/analog-direction and button levels into MSX general-purpose joystick port signals: 6-bit, active-low, {trigB, trigA, right, left, down, up}.
- Adds input synchronisation, SOCD (opposite-direction) resolution and timed autofire.
- Also presents the PSG-register-14 view of the port selected by PSG register 15 bit 6.

Parameters:
- TICK_DIV, 21477, clk_sys cycles per autofire tick (1 ms at 21.477 MHz); legal range 2..65535.
- AF_P1, 62, half-period in ticks for af_rate=1 (~8 Hz).
- AF_P2, 42, half-period in ticks for af_rate=2 (~12 Hz).
- AF_P3, 33, half-period in ticks for af_rate=3 (~15 Hz).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- p1_dir  in  4  player 1 {right,left,down,up}, active-high (D-pad OR analog-to-DPAD)
- p1_trig  in  2  player 1 {B,A} plain triggers, active-high
- p1_turbo  in  2  player 1 {B,A} autofire triggers, active-high
- p2_dir  in  4  player 2, as p1_dir
- p2_trig  in  2  player 2, as p1_trig
- p2_turbo  in  2  player 2, as p1_turbo
- socd_mode  in  2  0=pass both, 1=neutral, 2=last-input-wins, 3=treated as 1
- af_rate  in  2  0=autofire off (turbo acts as plain), 1..3 select AF_P1..AF_P3
- psg_port_sel  in  1  PSG R15 bit 6: 0=port 1, 1=port 2
- joy1_n  out  6  MSX port 1 pins, active-low
- joy2_n  out  6  MSX port 2 pins, active-low
- psg_joy_n  out  6  selected port for PSG R14[5:0], active-low

Behaviour:
- Reset (async assert, sync-released via internal 2-FF): joy1_n, joy2_n, psg_joy_n = 6'h3F. Sync registers, SOCD memories, prescaler, phase counters and phase bits cleared.
- Input sync: all p*_dir/trig/turbo pass through a 2-FF synchroniser. Config inputs are sampled through a single register.
- Latency:
  - Input change to joyN_n change = 3 clk_sys cycles, with autofire inactive.
  - psg_joy_n = 1 cycle after joyN_n, and 1 cycle after a psg_port_sel change.
- SOCD, applied per axis (up/down, left/right) per player:
  - mode 0: both bits pass.
  - mode 1: both pressed gives both released.
  - mode 2: a per-axis "last" register stores which bit most recently rose. When both are pressed, only the last-risen bit is asserted. If both rise in the same cycle, up/left wins. Releasing the winner while the other is held asserts the other on the next cycle.
- Prescaler: counter 0..TICK_DIV-1, free-running. tick = 1-cycle pulse at wrap.
- Autofire, per player:
  - Phase counter (16-bit) and phase bit.
  - When the OR of the player's turbo bits goes 0 to 1: phase := 1 (fire) and counter := 0, on that same cycle.
  - While any turbo bit is held: on each tick the counter increments. On reaching the selected half-period - 1 with tick, the counter goes to 0 and the phase toggles.
  - When no turbo bit is held: phase := 0, counter := 0.
  - trigX = trig[X] OR (turbo[X] AND phase).
  - af_rate = 0: trigX = trig[X] OR turbo[X]; counters held at 0.
  - af_rate change mid-burst: the new period applies from the next comparison. If counter >= new period - 1, it toggles on the next tick.
- Output: joyN_n = ~{trigB, trigA, right, left, down, up}, registered.
- Simultaneous events: a turbo rise on a tick cycle gives the restart priority over the increment.

Optional Feature:
- Macro: MSXJOY_AUTOFIRE_EN.
- Defined: the prescaler, phase logic and af_rate decoding are implemented as described above.
- Undefined: no prescaler or phase logic. af_rate is ignored and trigX = trig[X] OR turbo[X] always. Latency is unchanged.

Test Plan:
- Reset: hold reset_n=0 with all inputs 1 -> all outputs 6'h3F; release, dir=4'h1 -> joy1_n=6'h3E after 3 cycles, psg_joy_n=6'h3E after 4.
- SOCD:
  - mode 2: up rises, down rises 5 cycles later -> joy1_n[1:0]=2'b01 (down active); release down -> 2'b10.
  - mode 1: both pressed -> 2'b11.
  - mode 0: both pressed -> 2'b00.
- Autofire (TICK_DIV=4, AF_P1=3, af_rate=1): hold p1_turbo=2'b01 -> joy1_n[4] low 3 cycles later, toggles every 12 cycles. Release -> high in 3 cycles.
- Turbo plus plain: p2_trig=2'b10 held while p2_turbo=2'b10 pulsing -> joy2_n[5] constantly 0.
- Port select: p1 up, p2 trigA; psg_port_sel 0 -> psg_joy_n=6'h3E; set 1 -> 6'h2F one cycle later.
- Mid-operation reset: assert reset_n=0 during an autofire burst -> outputs 6'h3F immediately (async). After release with turbo still held, the first fire phase starts fresh (counter 0).
